// File: rtl/count_bcd_pkg.sv
// rtl/count_bcd_pkg.sv - shared types, 7-segment codes and digit saturation for the BCD counter
package count_bcd_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [6:0] seg_t;

   // Active-low segments, bit order {g,f,e,d,c,b,a}
   localparam seg_t SEG_0     = 7'b1000000;
   localparam seg_t SEG_1     = 7'b1111001;
   localparam seg_t SEG_2     = 7'b0100100;
   localparam seg_t SEG_3     = 7'b0110000;
   localparam seg_t SEG_4     = 7'b0011001;
   localparam seg_t SEG_5     = 7'b0010010;
   localparam seg_t SEG_6     = 7'b0000010;
   localparam seg_t SEG_7     = 7'b1111000;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0010000;
   localparam seg_t SEG_BLANK = 7'h7F;

   function automatic bcd_t bcd_sat(input bcd_t d);
      return (d > 4'd9) ? 4'd0 : d;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - single BCD digit to active-low 7-segment decoder
module bcd_to_7seg
   import count_bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/count_bcd_multi.sv
// rtl/count_bcd_multi.sv - multi-digit BCD up/down counter with prescaler, load, wrap pulse and 7-seg outputs
module count_bcd_multi
   import count_bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int N_MAX  = 5000
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  switch_in,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data_in,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   disp_out,
   output logic                  tc
);

   localparam int            PW      = (N_MAX > 1) ? $clog2(N_MAX) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(N_MAX - 1);

   logic [PW-1:0]       presc_q;
   logic                tick;
   logic [DIGITS:0]     cy;
   logic [4*DIGITS-1:0] cnt_next;
   logic [4*DIGITS-1:0] load_val;

   assign tick = (presc_q == PS_LAST);

   // A load restarts the period so the next step is a full period after it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         presc_q <= '0;
      else if (load || tick)
         presc_q <= '0;
      else
         presc_q <= presc_q + PW'(1);
   end

   // cy[k] is carry (up) or borrow (down) into digit k; cy[DIGITS] marks a full wrap
   assign cy[0] = 1'b1;

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic [3:0] d;
      logic       at_end;

      assign d       = bcd_out[4*k +: 4];
      assign at_end  = switch_in ? (d == 4'd9) : (d == 4'd0);
      assign cy[k+1] = cy[k] & at_end;

      assign cnt_next[4*k +: 4] = !cy[k] ? d
                                : at_end ? (switch_in ? 4'd0 : 4'd9)
                                : (switch_in ? d + 4'd1 : d - 4'd1);

      assign load_val[4*k +: 4] = bcd_sat(data_in[4*k +: 4]);

      bcd_to_7seg u_seg (
         .digit (bcd_out[4*k +: 4]),
         .seg   (disp_out[7*k +: 7])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcd_out <= '0;
         tc      <= 1'b0;
      end else if (load) begin
         bcd_out <= load_val;
         tc      <= 1'b0;
      end else if (tick && en) begin
         bcd_out <= cnt_next;
         tc      <= cy[DIGITS];
      end else begin
         tc      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_count_bcd_multi.sv
// tb/tb_count_bcd_multi.sv - scoreboard bench for count_bcd_multi with DIGITS=2, N_MAX=4
module tb_count_bcd_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        switch_in = 1'b1;
   logic        load = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [7:0]  bcd_out;
   logic [13:0] disp_out;
   logic        tc;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic [7:0] bcd;
      logic       tc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] prev_bcd = 8'h00;

   count_bcd_multi #(.DIGITS(2), .N_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .switch_in (switch_in),
      .load      (load),
      .data_in   (data_in),
      .bcd_out   (bcd_out),
      .disp_out  (disp_out),
      .tc        (tc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int dt, input logic [7:0] v, input logic t);
      exp_t e;
      e.cyc = cyc + dt;
      e.bcd = v;
      e.tc  = t;
      sb.push_back(e);
   endtask

   // An output event is any change of bcd_out or any cycle with tc high
   always @(negedge clk) begin
      exp_t e;
      if (bcd_out !== prev_bcd || tc !== 1'b0) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got bcd=%h tc=%b expected no event (cyc %0d)", bcd_out, tc, cyc);
         end else begin
            e = sb.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_bcd", {24'h0, bcd_out}, {24'h0, e.bcd});
            chk("ev_tc", {31'h0, tc}, {31'h0, e.tc});
            chk("ev_disp", {18'h0, disp_out}, {18'h0, seg_of(e.bcd[7:4]), seg_of(e.bcd[3:0])});
         end
      end
      prev_bcd = bcd_out;
   end

   initial begin
      rst = 1'b0;
      #1;
      chk("rst_bcd", {24'h0, bcd_out}, 32'h00);
      chk("rst_disp", {18'h0, disp_out}, {18'h0, 7'b1000000, 7'b1000000});
      chk("rst_tc", {31'h0, tc}, 32'h0);
      en = 1'b1;
      load = 1'b1;
      data_in = 8'h55;
      step(3);
      chk("rst_hold_bcd", {24'h0, bcd_out}, 32'h00);
      chk("rst_hold_tc", {31'h0, tc}, 32'h0);
      load = 1'b0;
      data_in = 8'h00;

      // count up from 00, one step every 4 clocks
      rst = 1'b1;
      switch_in = 1'b1;
      for (int i = 1; i <= 10; i++)
         expect_at(4*i, {4'(i / 10), 4'(i % 10)}, 1'b0);
      step(40);
      chk("up_10_bcd", {24'h0, bcd_out}, 32'h10);
      chk("up_10_disp_hi", {25'h0, disp_out[13:7]}, {25'h0, 7'b1111001});

      // load 99 then wrap up to 00
      load = 1'b1;
      data_in = 8'h99;
      expect_at(1, 8'h99, 1'b0);
      step(1);
      load = 1'b0;
      expect_at(4, 8'h00, 1'b1);
      step(4);
      chk("wrap_up_tc", {31'h0, tc}, 32'h1);
      step(1);
      chk("wrap_up_tc_clear", {31'h0, tc}, 32'h0);

      // load 00 (no visible change) then wrap down to 99, then 98
      switch_in = 1'b0;
      load = 1'b1;
      data_in = 8'h00;
      step(1);
      load = 1'b0;
      expect_at(4, 8'h99, 1'b1);
      expect_at(8, 8'h98, 1'b0);
      step(8);
      chk("down_98_bcd", {24'h0, bcd_out}, 32'h98);
      chk("down_98_tc", {31'h0, tc}, 32'h0);

      // invalid digit saturates to 0
      load = 1'b1;
      data_in = 8'hA3;
      expect_at(1, 8'h03, 1'b0);
      step(1);
      load = 1'b0;
      chk("sat_bcd", {24'h0, bcd_out}, 32'h03);

      // load on the tick cycle wins, no extra step
      step(3);
      load = 1'b1;
      data_in = 8'h42;
      expect_at(1, 8'h42, 1'b0);
      step(1);
      load = 1'b0;
      expect_at(4, 8'h41, 1'b0);
      step(4);

      // enable low freezes the count
      en = 1'b0;
      step(20);
      chk("frozen_bcd", {24'h0, bcd_out}, 32'h41);

      // reset mid-period clears at once; counting restarts a full period later
      step(2);
      en = 1'b1;
      rst = 1'b0;
      expect_at(0, 8'h00, 1'b0);
      #1;
      chk("rst_mid_bcd", {24'h0, bcd_out}, 32'h00);
      step(1);
      rst = 1'b1;
      switch_in = 1'b1;
      expect_at(4, 8'h01, 1'b0);
      step(4);

      // direction change mid-period gives exactly one step in the new direction
      step(2);
      switch_in = 1'b0;
      expect_at(2, 8'h00, 1'b0);
      step(2);
      step(2);
      switch_in = 1'b1;
      expect_at(2, 8'h01, 1'b0);
      step(2);
      en = 1'b0;
      step(8);
      chk("final_bcd", {24'h0, bcd_out}, 32'h01);
      chk("sb_drained", sb.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
